rr_op_sequencer: RTL
====================

Name: rr_op_sequencer

Overview:
- Hardwired control-step sequencer for register-register instructions. It generates the fetch (T0-T2) and execute (T3-T6) control strobes that the DataPath needs, so benches no longer hand-drive them per state.
- Decodes the opcode and register fields of the IR and drives one-hot register in/out selects, ALU op select and Z/LO/HI strobes.
- Generalises the fixed SHL sequence to all ALU, shift/rotate, unary, MUL/DIV, NOP and HALT operations.
- Supports a variable-latency memory read and a run/halt handshake.

Parameters:
IR_WIDTH, 32, instruction register width
NUM_REGS, 16, number of general registers; width of the one-hot selects
RSEL_W, 4, register field width; must be >= clog2(NUM_REGS)
ALU_OP_W, 5, width of alu_op

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-high reset
run  in  1  start or continue instruction execution
mem_ready  in  1  memory read data valid
ir  in  IR_WIDTH  current IR contents (valid from T3)
pc_out, zlow_out, zhigh_out, mdr_out  out  1 each  bus source strobes
mar_in, pc_in, mdr_in, ir_in, y_in, z_in, lo_in, hi_in  out  1 each  register load strobes
inc_pc  out  1  ALU forced to PC+1
md_read  out  1  MDR mux selects memory data
reg_in  out  NUM_REGS  one-hot register load
reg_out  out  NUM_REGS  one-hot register drive
alu_op  out  ALU_OP_W  ALU operation; equals the opcode during the ALU step, else 0
step  out  4  state code
halted  out  1  HALT executed
illegal  out  1  one-cycle pulse on an undecodable instruction

Behaviour:
- IR fields:
  - opcode = ir[IR_WIDTH-1 -: 5]
  - ra = next RSEL_W bits
  - rb = next RSEL_W bits
  - rc = next RSEL_W bits
- Opcode classes:
  - Binary: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL.
  - Multi: 15 MUL, 16 DIV.
  - Unary: 17 NEG, 18 NOT.
  - Control: 28 NOP, 29 HALT.
  - Anything else is illegal. A register index >= NUM_REGS is also illegal.
- States and step codes: IDLE=0, T0..T6=1..7, HALT=8. Outputs are Moore, decoded from state plus the IR fields; no output glitches from run or mem_ready except in T1 (below).
- Reset: on clear, state goes to IDLE asynchronously. All outputs are 0, including halted and illegal. A clear mid-instruction aborts with no strobes after reset.
- IDLE: all strobes 0. Go to T0 when run=1.
- T0: pc_out, mar_in, inc_pc, z_in. Next state T1.
- T1:
  - Asserts zlow_out, pc_in (first cycle only), md_read, mdr_in.
  - Holds md_read/mdr_in until mem_ready=1, then goes to T2. pc_in pulses exactly once per instruction regardless of wait length.
- T2: mdr_out, ir_in. Next state T3.
- T3 by class:
  - Binary: reg_out[rb], y_in.
  - Multi: reg_out[ra], y_in.
  - Unary: reg_out[rb], alu_op, z_in.
  - NOP: no strobes; next state is the end of the instruction.
  - HALT: next state HALT.
  - Illegal: illegal=1 for this cycle only, no strobes, next state is the end of the instruction.
- T4:
  - Binary: reg_out[rc], alu_op, z_in.
  - Multi: reg_out[rb], alu_op, z_in.
  - Unary: zlow_out, reg_in[ra], then end of instruction.
- T5:
  - Binary: zlow_out, reg_in[ra], then end of instruction.
  - Multi: zlow_out, lo_in.
- T6 (multi only): zhigh_out, hi_in, then end of instruction.
- End of instruction: next state is T0 if run=1, else IDLE. run is sampled only here and in IDLE; deasserting run mid-instruction completes the instruction.
- HALT: halted=1, all strobes 0. Stays there until clear; run is ignored.
- Exactly one reg_out bit is set when any is set; reg_in likewise. reg_in and reg_out are never both driven in the same cycle for the same register.
- Cycle counts with mem_ready tied 1:
  - Binary: 6 cycles (T0-T5).
  - Unary: 5 cycles.
  - Multi: 7 cycles.
  - NOP and illegal: 4 cycles.

Test Plan:
- clear mid-T4 of an ADD -> step=0 on the same edge, all outputs 0; run=1 afterwards restarts at T0.
- mem_ready=1, run=1, ir=SHL ra=1 rb=2 rc=3 (opcode 6) -> T3 reg_out=0x0004 y_in; T4 reg_out=0x0008 alu_op=6 z_in; T5 zlow_out reg_in=0x0002; next cycle step=1.
- mem_ready low for 3 cycles in T1 -> md_read/mdr_in held 4 cycles, pc_in high 1 cycle, T2 entered after mem_ready rises.
- MUL ra=4 rb=5 -> T3 reg_out=0x0010; T4 reg_out=0x0020 alu_op=15; T5 lo_in; T6 zhigh_out hi_in; 7 cycles total.
- Opcode 31, then NEG ra=6 rb=7 -> illegal pulses 1 cycle in T3, no reg_in; NEG T3 reg_out=0x0080 z_in alu_op=17; T4 reg_in=0x0040.
- HALT opcode 29 with run held 1 -> step=8, halted=1 indefinitely; only clear returns to step=0.

Source files
------------

// File: rtl/rr_op_sequencer_if.sv
// Sequencer <-> DataPath bundle: run/memory handshake, IR, control strobes.
interface rr_op_sequencer_if #(
    parameter int IR_WIDTH = 32,
    parameter int NUM_REGS = 16,
    parameter int ALU_OP_W = 5
);
    logic                run;
    logic                mem_ready;
    logic [IR_WIDTH-1:0] ir;
    logic                pc_out;
    logic                zlow_out;
    logic                zhigh_out;
    logic                mdr_out;
    logic                mar_in;
    logic                pc_in;
    logic                mdr_in;
    logic                ir_in;
    logic                y_in;
    logic                z_in;
    logic                lo_in;
    logic                hi_in;
    logic                inc_pc;
    logic                md_read;
    logic [NUM_REGS-1:0] reg_in;
    logic [NUM_REGS-1:0] reg_out;
    logic [ALU_OP_W-1:0] alu_op;
    logic [3:0]          step;
    logic                halted;
    logic                illegal;

    modport master (
        input  run, mem_ready, ir,
        output pc_out, zlow_out, zhigh_out, mdr_out,
        output mar_in, pc_in, mdr_in, ir_in, y_in, z_in, lo_in, hi_in,
        output inc_pc, md_read, reg_in, reg_out, alu_op,
        output step, halted, illegal
    );

    modport slave (
        output run, mem_ready, ir,
        input  pc_out, zlow_out, zhigh_out, mdr_out,
        input  mar_in, pc_in, mdr_in, ir_in, y_in, z_in, lo_in, hi_in,
        input  inc_pc, md_read, reg_in, reg_out, alu_op,
        input  step, halted, illegal
    );
endinterface

// File: rtl/rr_op_sequencer.sv
// Hardwired T0..T6 control-step sequencer for register-register instructions.
module rr_op_sequencer #(
    parameter int IR_WIDTH = 32,
    parameter int NUM_REGS = 16,
    parameter int RSEL_W   = 4,
    parameter int ALU_OP_W = 5
) (
    input  logic              clock,
    input  logic              clear,
    rr_op_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    state_t state_q, state_d;
    logic   pc_done_q, pc_done_d;

    logic [4:0]        opcode;
    logic [RSEL_W-1:0] ra, rb, rc;
    logic ra_ok, rb_ok, rc_ok, bad_reg;
    logic is_bin, is_mul, is_un, is_nop, is_hlt;
    logic c_bin, c_mul, c_un, c_ill;
    state_t eoi;

    assign opcode = bus.ir[IR_WIDTH-1 -: 5];
    assign ra     = bus.ir[IR_WIDTH-6 -: RSEL_W];
    assign rb     = bus.ir[IR_WIDTH-6-RSEL_W -: RSEL_W];
    assign rc     = bus.ir[IR_WIDTH-6-2*RSEL_W -: RSEL_W];

    assign ra_ok = 32'(ra) < NUM_REGS;
    assign rb_ok = 32'(rb) < NUM_REGS;
    assign rc_ok = 32'(rc) < NUM_REGS;

    assign is_bin = opcode <= 5'd8;
    assign is_mul = (opcode == 5'd15) || (opcode == 5'd16);
    assign is_un  = (opcode == 5'd17) || (opcode == 5'd18);
    assign is_nop = opcode == 5'd28;
    assign is_hlt = opcode == 5'd29;

    // Only the fields an instruction class actually uses are range-checked.
    assign bad_reg = (is_bin && !(ra_ok && rb_ok && rc_ok))
                   || ((is_mul || is_un) && !(ra_ok && rb_ok));

    assign c_bin = is_bin && !bad_reg;
    assign c_mul = is_mul && !bad_reg;
    assign c_un  = is_un && !bad_reg;
    assign c_ill = bad_reg
                 || !(is_bin || is_mul || is_un || is_nop || is_hlt);

    assign eoi = bus.run ? S_T0 : S_IDLE;

    function automatic logic [NUM_REGS-1:0] onehot(
        input logic [RSEL_W-1:0] idx
    );
        onehot = '0;
        for (int j = 0; j < NUM_REGS; j++)
            if (32'(idx) == j) onehot[j] = 1'b1;
    endfunction

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= S_IDLE;
            pc_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_done_q <= pc_done_d;
        end
    end

    assign bus.step   = state_q;
    assign bus.halted = state_q == S_HALT;

    always_comb begin
        state_d       = state_q;
        pc_done_d     = state_q == S_T1;
        bus.pc_out    = 1'b0;
        bus.zlow_out  = 1'b0;
        bus.zhigh_out = 1'b0;
        bus.mdr_out   = 1'b0;
        bus.mar_in    = 1'b0;
        bus.pc_in     = 1'b0;
        bus.mdr_in    = 1'b0;
        bus.ir_in     = 1'b0;
        bus.y_in      = 1'b0;
        bus.z_in      = 1'b0;
        bus.lo_in     = 1'b0;
        bus.hi_in     = 1'b0;
        bus.inc_pc    = 1'b0;
        bus.md_read   = 1'b0;
        bus.reg_in    = '0;
        bus.reg_out   = '0;
        bus.alu_op    = '0;
        bus.illegal   = 1'b0;
        unique case (state_q)
            S_IDLE: if (bus.run) state_d = S_T0;
            S_T0: begin
                bus.pc_out = 1'b1;
                bus.mar_in = 1'b1;
                bus.inc_pc = 1'b1;
                bus.z_in   = 1'b1;
                state_d    = S_T1;
            end
            S_T1: begin
                // pc_done_q marks wait cycles so PC loads only once
                bus.zlow_out = 1'b1;
                bus.pc_in    = !pc_done_q;
                bus.md_read  = 1'b1;
                bus.mdr_in   = 1'b1;
                if (bus.mem_ready) state_d = S_T2;
            end
            S_T2: begin
                bus.mdr_out = 1'b1;
                bus.ir_in   = 1'b1;
                state_d     = S_T3;
            end
            S_T3: begin
                if (c_bin) begin
                    bus.reg_out = onehot(rb);
                    bus.y_in    = 1'b1;
                    state_d     = S_T4;
                end else if (c_mul) begin
                    bus.reg_out = onehot(ra);
                    bus.y_in    = 1'b1;
                    state_d     = S_T4;
                end else if (c_un) begin
                    bus.reg_out = onehot(rb);
                    bus.alu_op  = ALU_OP_W'(opcode);
                    bus.z_in    = 1'b1;
                    state_d     = S_T4;
                end else if (c_ill) begin
                    bus.illegal = 1'b1;
                    state_d     = eoi;
                end else if (is_hlt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = eoi;
                end
            end
            S_T4: begin
                if (c_un) begin
                    bus.zlow_out = 1'b1;
                    bus.reg_in   = onehot(ra);
                    state_d      = eoi;
                end else begin
                    bus.reg_out = c_mul ? onehot(rb) : onehot(rc);
                    bus.alu_op  = ALU_OP_W'(opcode);
                    bus.z_in    = 1'b1;
                    state_d     = S_T5;
                end
            end
            S_T5: begin
                bus.zlow_out = 1'b1;
                if (c_mul) begin
                    bus.lo_in = 1'b1;
                    state_d   = S_T6;
                end else begin
                    bus.reg_in = onehot(ra);
                    state_d    = eoi;
                end
            end
            S_T6: begin
                bus.zhigh_out = 1'b1;
                bus.hi_in     = 1'b1;
                state_d       = eoi;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end
endmodule
